// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the load/store unit (A) and the loader port (B)
// for the shared data memory: legality check, one-cycle strobe, held response.
module dmem_arbiter #(
  parameter int MEM_BYTES = 124,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  input  logic [2:0]        a_func3,
  input  logic              a_we,
  output logic              a_resp_valid,
  input  logic              a_resp_ready,
  output logic [31:0]       a_rdata,
  output logic              a_fault,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  input  logic [2:0]        b_func3,
  input  logic              b_we,
  output logic              b_resp_valid,
  input  logic              b_resp_ready,
  output logic [31:0]       b_rdata,
  output logic              b_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t state;
  logic   last_b;
  logic   own_b;

  logic              win_a;
  logic              win_b;
  logic              hs;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_f3;
  logic              sel_we;
  logic [1:0]        size_m1;
  logic [ADDR_W:0]   end_addr;
  logic              bad_f3;
  logic              bad_we;
  logic              misal;
  logic              bad_rng;
  logic              legal;

  // last_b set means B was served last, so A wins a tie
  assign win_a = a_req_valid & (~b_req_valid | last_b);
  assign win_b = b_req_valid & (~a_req_valid | ~last_b);

  assign a_req_ready = (state == IDLE) & win_a;
  assign b_req_ready = (state == IDLE) & win_b;
  assign hs          = a_req_ready | b_req_ready;

  assign sel_addr  = win_b ? b_addr  : a_addr;
  assign sel_wdata = win_b ? b_wdata : a_wdata;
  assign sel_f3    = win_b ? b_func3 : a_func3;
  assign sel_we    = win_b ? b_we    : a_we;

  always_comb begin
    size_m1 = 2'd3;
    unique case (1'b1)
      sel_f3[1:0] == 2'b00: size_m1 = 2'd0;
      sel_f3[1:0] == 2'b01: size_m1 = 2'd1;
      default:              size_m1 = 2'd3;
    endcase
  end

  // one extra bit so a request near the top of the space cannot wrap
  assign end_addr = {1'b0, sel_addr} + (ADDR_W+1)'(size_m1);

  assign bad_f3  = (sel_f3[1:0] == 2'b11) | (sel_f3 == 3'b110);
  assign bad_we  = sel_we & sel_f3[2];
  assign misal   = ((sel_f3[1:0] == 2'b01) & sel_addr[0]) |
                   ((sel_f3[1:0] == 2'b10) & (|sel_addr[1:0]));
  assign bad_rng = end_addr >= LIMIT;
  assign legal   = ~(bad_f3 | bad_we | misal | bad_rng);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_b       <= 1'b1;
      own_b        <= 1'b0;
      a_resp_valid <= 1'b0;
      a_rdata      <= '0;
      a_fault      <= 1'b0;
      b_resp_valid <= 1'b0;
      b_rdata      <= '0;
      b_fault      <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      mem_func3    <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            own_b  <= b_req_ready;
            last_b <= b_req_ready;
            if (legal) begin
              mem_address <= sel_addr;
              mem_wdata   <= sel_wdata;
              mem_func3   <= sel_f3;
              mem_read    <= ~sel_we;
              mem_write   <= sel_we;
              state       <= ACCESS;
            end else begin
              if (b_req_ready) begin
                b_rdata      <= '0;
                b_fault      <= 1'b1;
                b_resp_valid <= 1'b1;
              end else begin
                a_rdata      <= '0;
                a_fault      <= 1'b1;
                a_resp_valid <= 1'b1;
              end
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (own_b) begin
            b_rdata      <= mem_read ? mem_rdata : '0;
            b_fault      <= 1'b0;
            b_resp_valid <= 1'b1;
          end else begin
            a_rdata      <= mem_read ? mem_rdata : '0;
            a_fault      <= 1'b0;
            a_resp_valid <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (own_b && b_resp_ready) begin
            b_resp_valid <= 1'b0;
            state        <= IDLE;
          end else if (!own_b && a_resp_ready) begin
            a_resp_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed plan plus random traffic checked against
// a transaction-level byte-array model of the memory.
module tb_dmem_arbiter;

  localparam int MB = 124;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req_valid, a_req_ready, a_we, a_resp_valid, a_resp_ready, a_fault;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [2:0]  a_func3;
  logic        b_req_valid, b_req_ready, b_we, b_resp_valid, b_resp_ready, b_fault;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [2:0]  b_func3;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;
  logic        mem_read, mem_write;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MB), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_func3(a_func3), .a_we(a_we),
    .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
    .a_rdata(a_rdata), .a_fault(a_fault),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_func3(b_func3), .b_we(b_we),
    .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
    .b_rdata(b_rdata), .b_fault(b_fault),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_func3(mem_func3),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // memory environment: combinational read with extension, write on edge
  logic [7:0]  env_mem [MB];
  logic        env_init = 1'b0;
  logic [31:0] env_w;
  int          wsz;

  always_comb begin
    wsz = (mem_func3[1:0] == 2'b00) ? 1 : (mem_func3[1:0] == 2'b01) ? 2 : 4;
  end

  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < MB; i++) env_mem[i] <= 8'(i * 37 + 5);
      env_init <= 1'b1;
    end else if (mem_write) begin
      for (int i = 0; i < 4; i++)
        if (i < wsz && mem_address < 32'(MB - i))
          env_mem[mem_address + 32'(i)] <= mem_wdata[8*i +: 8];
    end
  end

  always_comb begin
    env_w = '0;
    mem_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (mem_address < 32'(MB - i)) env_w[8*i +: 8] = env_mem[mem_address + 32'(i)];
    if (mem_read) begin
      case (mem_func3)
        3'b000:  mem_rdata = {{24{env_w[7]}}, env_w[7:0]};
        3'b001:  mem_rdata = {{16{env_w[15]}}, env_w[15:0]};
        3'b100:  mem_rdata = {24'd0, env_w[7:0]};
        3'b101:  mem_rdata = {16'd0, env_w[15:0]};
        default: mem_rdata = env_w;
      endcase
    end
  end

  // reference model
  logic [7:0] ref_mem [MB];

  function automatic bit ref_fault(input logic [31:0] addr, input logic [2:0] f3,
                                   input bit we);
    int sz;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    sz = 1 << f3[1:0];
    if (addr % sz != 0) return 1'b1;
    if (longint'({32'd0, addr}) + sz > MB) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    int sz;
    longint v;
    sz = 1 << f3[1:0];
    v = 0;
    for (int i = 0; i < sz; i++) v += longint'(ref_mem[addr + 32'(i)]) << (8 * i);
    if (f3 < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] f3);
    int sz;
    sz = 1 << f3[1:0];
    for (int i = 0; i < sz; i++) ref_mem[addr + 32'(i)] = 8'(wd >> (8 * i));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    a_req_valid = 0; a_addr = 0; a_wdata = 0; a_func3 = 0; a_we = 0; a_resp_ready = 1;
    b_req_valid = 0; b_addr = 0; b_wdata = 0; b_func3 = 0; b_we = 0; b_resp_ready = 1;
  endtask

  // one isolated request; checks grant, strobe timing and response
  task automatic single_req(input bit who, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] f3, input bit we);
    bit          ef;
    logic [31:0] ed;
    ef = ref_fault(addr, f3, we);
    ed = (!ef && !we) ? ref_load(addr, f3) : 32'd0;
    @(negedge clk);
    a_resp_ready = 1; b_resp_ready = 1;
    if (who) begin
      b_req_valid = 1; b_addr = addr; b_wdata = wd; b_func3 = f3; b_we = we;
    end else begin
      a_req_valid = 1; a_addr = addr; a_wdata = wd; a_func3 = f3; a_we = we;
    end
    #1;
    chk("req_ready", who ? b_req_ready : a_req_ready, 1);
    chk("other_ready", who ? a_req_ready : b_req_ready, 0);
    @(negedge clk);
    a_req_valid = 0; b_req_valid = 0;
    chk("t1_read", mem_read, (!ef && !we));
    chk("t1_write", mem_write, (!ef && we));
    chk("t1_resp_valid", who ? b_resp_valid : a_resp_valid, ef);
    if (ef) begin
      chk("fault", who ? b_fault : a_fault, 1);
      chk("fault_rdata", who ? b_rdata : a_rdata, 0);
    end else begin
      chk("mem_address", mem_address, addr);
      chk("mem_func3", 32'(mem_func3), 32'(f3));
      if (we) chk("mem_wdata", mem_wdata, wd);
      @(negedge clk);
      chk("t2_strobes", {mem_read, mem_write}, 0);
      chk("t2_resp_valid", who ? b_resp_valid : a_resp_valid, 1);
      chk("rdata", who ? b_rdata : a_rdata, ed);
      chk("no_fault", who ? b_fault : a_fault, 0);
      if (we) ref_store(addr, wd, f3);
    end
    chk("nonowner_valid", who ? a_resp_valid : b_resp_valid, 0);
  endtask

  initial begin
    int grants, last_c, owner;
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'(i * 37 + 5);
    idle_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {a_req_ready, b_req_ready}, 0);
    chk("rst_resp_valid", {a_resp_valid, b_resp_valid}, 0);
    chk("rst_fault", {a_fault, b_fault}, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_func3", 32'(mem_func3), 0);
    rst_n = 1;

    // contention: A and B continuously valid
    @(negedge clk);
    a_req_valid = 1; a_addr = 0; a_func3 = 3'b010;
    b_req_valid = 1; b_addr = 4; b_func3 = 3'b010;
    grants = 0; last_c = 0; owner = -1;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      #1;
      chk("one_ready", 32'(a_req_ready & b_req_ready), 0);
      if (owner == 0) chk("b_valid_while_a", b_resp_valid, 0);
      if (owner == 1) chk("a_valid_while_b", a_resp_valid, 0);
      if (a_req_ready || b_req_ready) begin
        chk("grant_order", b_req_ready, 32'(grants % 2));
        if (grants > 0) chk("grant_spacing", c - last_c, 3);
        last_c = c;
        owner = b_req_ready ? 1 : 0;
        grants++;
      end
      @(negedge clk);
    end
    chk("grant_count", grants, 4);
    a_req_valid = 0; b_req_valid = 0;
    repeat (3) @(negedge clk);
    chk("cont_a_rdata", a_rdata, ref_load(0, 3'b010));
    chk("cont_b_rdata", b_rdata, ref_load(4, 3'b010));

    // loader preloads a word, then A reads it back
    single_req(1, 8, 32'h8000_00F0, 3'b010, 1);
    single_req(0, 8, 0, 3'b010, 0);
    chk("lw8_value", a_rdata, 32'h8000_00F0);

    // fault cases and range boundaries
    single_req(0, 6, 0, 3'b010, 0);
    single_req(0, 3, 0, 3'b001, 0);
    single_req(0, 32'h20, 32'hAB, 3'b100, 1);
    single_req(0, 121, 0, 3'b010, 0);
    single_req(1, 0, 0, 3'b011, 0);
    single_req(0, 120, 0, 3'b010, 0);
    single_req(1, 123, 0, 3'b100, 0);
    single_req(0, 32'hFFFF_FFFC, 0, 3'b010, 0);

    // backpressure on B while A waits
    @(negedge clk);
    b_req_valid = 1; b_addr = 10; b_wdata = 32'h1234; b_func3 = 3'b001; b_we = 1;
    b_resp_ready = 0;
    #1 chk("bp_b_ready", b_req_ready, 1);
    @(negedge clk);
    b_req_valid = 0;
    a_req_valid = 1; a_addr = 10; a_func3 = 3'b101; a_we = 0;
    #1;
    chk("bp_access_write", mem_write, 1);
    chk("bp_a_blocked_access", a_req_ready, 0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_b_held", b_resp_valid, 1);
      chk("bp_a_blocked", a_req_ready, 0);
      chk("bp_b_rdata", b_rdata, 0);
      @(negedge clk);
    end
    b_resp_ready = 1;
    @(negedge clk);
    #1;
    chk("bp_b_dropped", b_resp_valid, 0);
    chk("bp_a_granted", a_req_ready, 1);
    a_req_valid = 0;
    ref_store(10, 32'h1234, 3'b001);
    single_req(0, 10, 0, 3'b101, 0);
    chk("lhu10_value", a_rdata, 32'h0000_1234);

    // random traffic
    for (int n = 0; n < 120; n++) begin
      logic [31:0] ad;
      if ($urandom % 8 == 0) ad = 32'hFFFF_FFF0 + ($urandom % 16);
      else ad = $urandom % 128;
      single_req(1'($urandom % 2), ad, $urandom, 3'($urandom % 8), 1'($urandom % 2));
    end

    // reset during a store access
    @(negedge clk);
    a_req_valid = 1; a_addr = 40; a_wdata = 32'hDEAD_BEEF; a_func3 = 3'b010; a_we = 1;
    @(negedge clk);
    a_req_valid = 0;
    #1 chk("mid_write", mem_write, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_strobes", {mem_read, mem_write}, 0);
    chk("mid_rst_valid", {a_resp_valid, b_resp_valid}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    a_req_valid = 1; a_addr = 0; a_func3 = 3'b010; a_we = 0;
    b_req_valid = 1; b_addr = 4; b_func3 = 3'b010; b_we = 0;
    #1;
    chk("post_rst_a_ready", a_req_ready, 1);
    chk("post_rst_b_ready", b_req_ready, 0);
    chk("post_rst_valid", {a_resp_valid, b_resp_valid}, 0);
    a_req_valid = 0; b_req_valid = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared byte-addressed data memory.
- The memory port carries address, wdata, func3 and MemRead/MemWrite strobes, and returns combinational rdata.
- Requester A is the core load/store unit; requester B is the program-loader/debug port.
- The block grants one request at a time with round-robin fairness, checks alignment/range/func3 legality, drives the memory strobes for exactly one cycle, and returns a registered response through a valid/ready handshake.

Parameters:
- MEM_BYTES, 124, number of bytes in the memory array; legal byte addresses are 0..MEM_BYTES-1.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- a_req_valid  in  1  A request valid.
- a_req_ready  out  1  A request accepted when valid&ready.
- a_addr  in  ADDR_W  A byte address.
- a_wdata  in  32  A store data.
- a_func3  in  3  A access size/sign (RV32 load/store func3).
- a_we  in  1  A: 1=store, 0=load.
- a_resp_valid  out  1  A response valid.
- a_resp_ready  in  1  A response consumed.
- a_rdata  out  32  A load data.
- a_fault  out  1  A access faulted.
- b_*  (same eight signals for requester B).
- mem_address  out  ADDR_W  to memory.
- mem_wdata  out  32  to memory.
- mem_func3  out  3  to memory.
- mem_read  out  1  MemRead strobe.
- mem_write  out  1  MemWrite strobe.
- mem_rdata  in  32  from memory, combinational.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE; last_grant=B, so A wins the first contention.
  - All ready, resp_valid, fault, mem_read and mem_write outputs 0.
  - rdata, mem_address, mem_wdata, mem_func3 all 0.
- States: IDLE, ACCESS, RESP.
- IDLE, grant:
  - Winner = the only valid requester. If both are valid, winner = the one not equal to last_grant.
  - x_req_ready = (state==IDLE) && winner==x. Combinational; at most one ready is high.
- IDLE, on handshake:
  - Latch addr/wdata/func3/we and owner; set last_grant=owner.
  - Evaluate legality:
    - func3 in {011,110,111}.
    - we=1 with func3 in {100,101}.
    - Misaligned: half with addr[0]!=0; word with addr[1:0]!=0.
    - addr+size-1 >= MEM_BYTES (size 1/2/4), computed without overflow wrap.
  - Legal -> ACCESS. Illegal -> RESP with fault=1, rdata=0; memory is never strobed.
- ACCESS (exactly 1 cycle):
  - mem_read=!we, mem_write=we; mem_address/wdata/func3 = latched values.
  - At cycle end, capture mem_rdata into the owner's rdata if load; rdata=0 for stores.
  - -> RESP.
- RESP:
  - owner's resp_valid=1; rdata/fault held stable while valid&&!ready.
  - On resp_ready -> IDLE; resp_valid drops next cycle.
  - No new grant while in ACCESS or RESP.
- Strobes are registered outputs, high only in ACCESS; never both high.
- Latency from request handshake at edge T:
  - Legal access: strobes in cycle T+1, resp_valid from T+2.
  - Fault: resp_valid from T+1.
- Throughput: one access per 3 cycles when resp_ready is tied high; the next grant occurs in the IDLE cycle.
- Non-owner outputs: resp_valid=0 always; rdata/fault hold their last value.
- Requester dropping valid before ready: the request is ignored; no state change.
- Reset asserted mid-ACCESS: strobes drop asynchronously, the response is discarded, the store may or may not have committed.
- Store data path is pass-through; sign/zero extension is performed by memory per func3. The block does not modify data.

Test Plan:
- Single A load: memory preloaded with word 0x8000_00F0 at byte 8; a_addr=8, func3=010, we=0. Required: a_req_ready=1 in IDLE, mem_read=1 for exactly one cycle with mem_address=8, a_resp_valid at T+2, a_rdata=0x8000_00F0, a_fault=0.
- Contention fairness: A and B both valid continuously for 4 requests, resp_ready=1. Required: grant order A,B,A,B; only one ready high per cycle; b_resp_valid never high while A owns.
- Fault cases, each with no strobe and fault=1, rdata=0, resp_valid at T+1:
  - lw at addr=6;
  - lh at addr=3;
  - sb with func3=100;
  - lw at addr=121 when MEM_BYTES=124;
  - func3=011.
- Backpressure: B sh addr=10 wdata=0x1234, then b_resp_ready held 0 for 5 cycles while A requests. Required: b_resp_valid held, a_req_ready=0 throughout, A granted only after B response consumed; subsequent lhu at 10 returns 0x0000_1234.
- Reset mid-operation: rst_n pulled low during ACCESS. Required: mem_read/mem_write and all resp_valid go 0 immediately; after release, state IDLE and the first contention goes to A.
